// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared widths, opcodes, ALU selects, FSM states and decode helper
package alu_op_sequencer_pkg;
  localparam int DATA_W = 8;
  localparam int NREGS = 8;
  localparam int AW = 3;
  localparam int INSTR_W = 32;
  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05
  } opcode_e;
  typedef enum logic [2:0] {
    SEL_ADD = 3'b010,
    SEL_SUB = 3'b011,
    SEL_AND = 3'b100,
    SEL_OR  = 3'b101
  } alu_sel_e;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;
  function automatic logic is_illegal(input logic [INSTR_W-1:0] ins);
    return ins[31:24] > OP_OR || |ins[23:19] || (ins[31:24] != OP_LOADI && |ins[15:11]) || |ins[7:3];
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction handshake plus ALU operand/result bus
interface alu_op_sequencer_if;
  import alu_op_sequencer_pkg::*;
  logic instr_valid;
  logic instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0] alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic alu_cout;
  modport master(output instr_valid, instr, alu_result, alu_cout, input instr_ready, alu_a, alu_b, alu_sel);
  modport slave(input instr_valid, instr, alu_result, alu_cout, output instr_ready, alu_a, alu_b, alu_sel);
endinterface

// File: rtl/alu_op_sequencer_reg_file_8x8.sv
// alu_op_sequencer_reg_file_8x8: 8x8 register file, two async reads, debug read, one sync write
module alu_op_sequencer_reg_file_8x8
  import alu_op_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra0,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];
  assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes instructions, drives the external ALU and writes results back
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus,
  output logic              done,
  output logic              illegal,
  output logic              carry,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d, rf_a, rf_b, wdata;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic cout_q, cout_d, carry_q, carry_d, done_q, done_d, illegal_q, illegal_d;
  logic [7:0] op;
  assign op = instr_q[31:24];
  // MOV takes the operand latched in DECODE so dest==src sees the pre-write value
  assign wdata = op == OP_LOADI ? instr_q[15:8] : op == OP_MOV ? alu_a_q : res_q;
  alu_op_sequencer_reg_file_8x8 u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (state_q == S_WB),
    .waddr    (instr_q[18:16]),
    .wdata    (wdata),
    .ra0      (instr_q[10:8]),
    .ra1      (instr_q[2:0]),
    .dbg_addr (dbg_addr),
    .rd0      (rf_a),
    .rd1      (rf_b),
    .dbg_data (dbg_data)
  );
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_sel_d = alu_sel_q;
    res_d = res_q;
    cout_d = cout_q;
    carry_d = carry_q;
    done_d = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.instr_valid) begin
        instr_d = bus.instr;
        state_d = S_DECODE;
      end
      S_DECODE: if (is_illegal(instr_q)) begin
        illegal_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        alu_a_d = rf_a;
        alu_b_d = rf_b;
        alu_sel_d = op[2:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = bus.alu_result;
        cout_d = bus.alu_cout;
        state_d = S_WB;
      end
      default: begin
        carry_d = op == OP_ADD ? cout_q : carry_q;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_sel_q <= '0;
      res_q <= '0;
      cout_q <= 1'b0;
      carry_q <= 1'b0;
      done_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q <= res_d;
      cout_q <= cout_d;
      carry_q <= carry_d;
      done_q <= done_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.instr_ready = state_q == S_IDLE;
  assign bus.alu_a = alu_a_q;
  assign bus.alu_b = alu_b_q;
  assign bus.alu_sel = alu_sel_q;
  assign done = done_q;
  assign illegal = illegal_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench with a behavioural ALU on the bus
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done, illegal, carry;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  logic [8:0] alu_o;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_c, fin_c, d1, first_rdy;
  logic got_done, got_ill, seen_done;
  logic [7:0] ex_a, ex_b;
  logic [2:0] ex_sel;
  alu_op_sequencer_if bus();
  alu_op_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .done     (done),
    .illegal  (illegal),
    .carry    (carry),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    alu_o = 9'd0;
    case (bus.alu_sel)
      3'b010: alu_o = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b011: alu_o = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
      3'b100: alu_o = {1'b0, bus.alu_a & bus.alu_b};
      3'b101: alu_o = {1'b0, bus.alu_a | bus.alu_b};
      default: alu_o = 9'd0;
    endcase
  end
  assign bus.alu_result = alu_o[7:0];
  assign bus.alu_cout = alu_o[8];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reg(input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    dbg_addr = a;
    #1;
    chk($sformatf("r%0d", a), {24'd0, dbg_data}, {24'd0, exp});
  endtask
  // Call in the low clock phase; returns at the negedge where done/illegal is seen
  task automatic run(input logic [31:0] ins);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    for (int i = 0; i < 8 && !bus.instr_ready; i++) @(negedge clk);
    chk("ready_before_accept", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    acc_c = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        ex_a = bus.alu_a;
        ex_b = bus.alu_b;
        ex_sel = bus.alu_sel;
      end
      if (done || illegal) break;
      @(negedge clk);
    end
    fin_c = cyc;
    got_done = done;
    got_ill = illegal;
  endtask
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
    chk("rst_alu_sel", {29'd0, bus.alu_sel}, 32'd0);
    chk("rst_flags", {29'd0, carry, done, illegal}, 32'd0);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 8'h00);
    // 1: LOADI pair, retire spacing
    run(32'h00_01_05_00);
    chk("loadi_done", {31'd0, got_done}, 32'd1);
    d1 = fin_c;
    run(32'h00_02_03_00);
    chk("loadi_spacing", fin_c - d1, 32'd4);
    chk_reg(3'd1, 8'h05);
    chk_reg(3'd2, 8'h03);
    // 2: ADD r3,r1,r2
    run(32'h02_03_01_02);
    chk("add_sel", {29'd0, ex_sel}, 32'd2);
    chk("add_a", {24'd0, ex_a}, 32'h05);
    chk("add_b", {24'd0, ex_b}, 32'h03);
    chk("add_latency", fin_c - acc_c, 32'd3);
    chk("add_done", {31'd0, got_done}, 32'd1);
    chk_reg(3'd3, 8'h08);
    chk("add_carry0", {31'd0, carry}, 32'd0);
    // 3: SUB/AND/OR; SUB 5-3 carries out of the ALU but must not touch carry
    run(32'h03_04_01_02);
    chk("sub_sel", {29'd0, ex_sel}, 32'd3);
    run(32'h04_05_01_02);
    chk("and_sel", {29'd0, ex_sel}, 32'd4);
    run(32'h05_06_01_02);
    chk("or_sel", {29'd0, ex_sel}, 32'd5);
    chk_reg(3'd4, 8'h02);
    chk_reg(3'd5, 8'h01);
    chk_reg(3'd6, 8'h07);
    chk("sub_carry_kept", {31'd0, carry}, 32'd0);
    // 4: wraparound ADD with dest==src, then MOV keeps carry
    run(32'h00_01_FF_00);
    run(32'h00_02_01_00);
    run(32'h02_01_01_02);
    chk_reg(3'd1, 8'h00);
    chk("add_carry1", {31'd0, carry}, 32'd1);
    run(32'h01_07_01_00);
    chk_reg(3'd7, 8'h00);
    run(32'h01_00_04_00);
    chk_reg(3'd0, 8'h02);
    chk("mov_carry_kept", {31'd0, carry}, 32'd1);
    run(32'h03_03_06_05);
    chk_reg(3'd3, 8'h06);
    chk("sub2_carry_kept", {31'd0, carry}, 32'd1);
    // 5: illegal encodings
    run(32'h07_01_00_00);
    chk("ill_op_pulse", {30'd0, got_ill, got_done}, 32'd2);
    chk("ill_op_latency", fin_c - acc_c, 32'd1);
    chk("ill_op_ready", {31'd0, bus.instr_ready}, 32'd1);
    run(32'h00_09_55_00);
    chk("ill_dest_pulse", {30'd0, got_ill, got_done}, 32'd2);
    run(32'h02_03_08_02);
    chk("ill_src1_pulse", {30'd0, got_ill, got_done}, 32'd2);
    run(32'h05_06_01_0A);
    chk("ill_src2_pulse", {30'd0, got_ill, got_done}, 32'd2);
    chk_reg(3'd1, 8'h00);
    chk_reg(3'd3, 8'h06);
    chk_reg(3'd6, 8'h07);
    chk("ill_carry_kept", {31'd0, carry}, 32'd1);
    // 6: valid held high, second instruction presented while busy
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = 32'h00_05_FF_00;
    @(posedge clk);
    @(negedge clk);
    acc_c = cyc;
    bus.instr = 32'h02_06_05_05;
    first_rdy = -1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done = 1'b1;
      if (bus.instr_ready) begin
        first_rdy = cyc - acc_c;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_ready_gap", first_rdy, 32'd3);
    chk("b2b_first_done", {31'd0, seen_done}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    acc_c = cyc;
    for (int i = 0; i < 8 && !done; i++) @(negedge clk);
    chk("b2b_second_latency", cyc - acc_c, 32'd3);
    chk_reg(3'd5, 8'hFF);
    chk_reg(3'd6, 8'hFE);
    // reset while ADD r1,r5,r6 is in EXEC
    bus.instr_valid = 1'b1;
    bus.instr = 32'h02_01_05_06;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_a", {24'd0, bus.alu_a}, 32'hFF);
    chk("exec_b", {24'd0, bus.alu_b}, 32'hFE);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
    chk("mid_rst_carry", {31'd0, carry}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("mid_rst_no_done", {31'd0, seen_done}, 32'd0);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
